// File: rtl/isa_pkg.sv
// Shared ISA constants: instruction kinds, opcodes, funct codes and field widths.
// The main control decoder imports the same package, so both sides agree on encodings.
package isa_pkg;

  localparam int KIND_W   = 5;
  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int WORD_W   = 32;

  typedef enum logic [KIND_W-1:0] {
    ADD, SUB, ADDI, ADDFP, MULFP, VADDFP, VMULFP, VSUMFP,
    SW, LW, SWFP, LWFP, VST, VLD, BEQ, BLT, J, VSETFP
  } instr_kind_t;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} instr_fmt_t;

  localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'b010000;
  localparam logic [OP_W-1:0] OP_FP     = 6'b000100;
  localparam logic [OP_W-1:0] OP_VFP    = 6'b001100;
  localparam logic [OP_W-1:0] OP_SW     = 6'b010001;
  localparam logic [OP_W-1:0] OP_LW     = 6'b010010;
  localparam logic [OP_W-1:0] OP_SWFP   = 6'b010101;
  localparam logic [OP_W-1:0] OP_LWFP   = 6'b010110;
  localparam logic [OP_W-1:0] OP_VST    = 6'b011101;
  localparam logic [OP_W-1:0] OP_VLD    = 6'b011110;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'b100000;
  localparam logic [OP_W-1:0] OP_BLT    = 6'b100001;
  localparam logic [OP_W-1:0] OP_J      = 6'b100010;
  localparam logic [OP_W-1:0] OP_VSETFP = 6'b111111;

  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_FADD = 6'b000001;
  localparam logic [FUNCT_W-1:0] FN_FMUL = 6'b000010;
  localparam logic [FUNCT_W-1:0] FN_VSUM = 6'b000011;

endpackage

// File: rtl/instr_encoder_if.sv
// Request stream and instruction-memory write port of the encoder, bundled for port lists.
interface instr_encoder_if #(parameter int ADDR_W = 8);
  import isa_pkg::*;

  logic                start;
  logic                req_valid;
  logic                req_ready;
  logic [KIND_W-1:0]   req_kind;
  logic [REG_W-1:0]    req_rd;
  logic [REG_W-1:0]    req_rs;
  logic [REG_W-1:0]    req_rt;
  logic [IMM_W-1:0]    req_imm;
  logic [TARGET_W-1:0] req_target;
  logic                req_last;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [WORD_W-1:0]   imem_wdata;
  logic                busy;
  logic                done;
  logic                err;
  logic [ADDR_W:0]     count;

  modport master (
    output start, req_valid, req_kind, req_rd, req_rs, req_rt, req_imm, req_target, req_last,
    input  req_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );

  modport slave (
    input  start, req_valid, req_kind, req_rd, req_rs, req_rt, req_imm, req_target, req_last,
    output req_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: symbolic instruction kind plus fields to a 32-bit word.
// Kinds outside the table report legal=0 and produce an all-zero word.
module instr_pack import isa_pkg::*; (
  input  logic [KIND_W-1:0]   kind,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TARGET_W-1:0] target,
  output logic                legal,
  output logic [WORD_W-1:0]   word
);

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  instr_fmt_t         fmt;

  always_comb begin
    legal = 1'b1;
    op    = OP_RTYPE;
    funct = '0;
    fmt   = FMT_I;
    case (kind)
      ADD:    begin op = OP_RTYPE;  funct = FN_ADD;  fmt = FMT_R; end
      SUB:    begin op = OP_RTYPE;  funct = FN_SUB;  fmt = FMT_R; end
      ADDFP:  begin op = OP_FP;     funct = FN_FADD; fmt = FMT_R; end
      MULFP:  begin op = OP_FP;     funct = FN_FMUL; fmt = FMT_R; end
      VADDFP: begin op = OP_VFP;    funct = FN_FADD; fmt = FMT_R; end
      VMULFP: begin op = OP_VFP;    funct = FN_FMUL; fmt = FMT_R; end
      VSUMFP: begin op = OP_VFP;    funct = FN_VSUM; fmt = FMT_R; end
      ADDI:   op = OP_ADDI;
      SW:     op = OP_SW;
      LW:     op = OP_LW;
      SWFP:   op = OP_SWFP;
      LWFP:   op = OP_LWFP;
      VST:    op = OP_VST;
      VLD:    op = OP_VLD;
      BEQ:    op = OP_BEQ;
      BLT:    op = OP_BLT;
      VSETFP: op = OP_VSETFP;
      J:      begin op = OP_J; fmt = FMT_J; end
      default: legal = 1'b0;
    endcase
  end

  // Branch offsets ride in imm untouched; loads name their destination in rt.
  always_comb begin
    word = '0;
    if (legal) begin
      case (fmt)
        FMT_R:   word = {op, rs, rt, rd, {SHAMT_W{1'b0}}, funct};
        FMT_I:   word = {op, rs, rt, imm};
        default: word = {op, target};
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential program loader: accepts instruction requests, packs them and writes
// consecutive instruction-memory words, one per cycle at full throughput.
module instr_encoder import isa_pkg::*; #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     count_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                err_q;
  logic                legal;
  logic [WORD_W-1:0]   word;
  logic                full;
  logic                accept;
  logic                overflow;
  logic                restart;

  instr_pack u_pack (
    .kind   (bus.req_kind),
    .rd     (bus.req_rd),
    .rs     (bus.req_rs),
    .rt     (bus.req_rt),
    .imm    (bus.req_imm),
    .target (bus.req_target),
    .legal  (legal),
    .word   (word)
  );

  // count moves on the accepting edge, so ready already reflects the word in flight.
  assign full     = (count_q == DEPTH_C);
  assign accept   = bus.req_valid && bus.req_ready;
  assign overflow = (state == LOAD) && bus.req_valid && full;
  assign restart  = (state != LOAD) && bus.start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    if ((accept && bus.req_last) || overflow) state_next = DONE;
      DONE:    if (bus.start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (restart) begin
        wr_ptr  <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end
      if (overflow) err_q <= 1'b1;
      if (accept) begin
        if (legal) begin
          we_q    <= 1'b1;
          addr_q  <= wr_ptr;
          wdata_q <= word;
          wr_ptr  <= wr_ptr + 1'b1;
          count_q <= count_q + 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready  = (state == LOAD) && !full;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = (state == LOAD);
  assign bus.done       = (state == DONE);
  assign bus.err        = err_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded bench for instr_encoder: a full-depth instance for the encoding scenarios
// and a DEPTH=4 instance for the overflow boundary.
module tb_instr_encoder;
  import isa_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(8)) bus();
  instr_encoder_if #(.ADDR_W(2)) bus4();

  instr_encoder #(.DEPTH(256)) dut  (.clk(clk), .reset(reset), .bus(bus));
  instr_encoder #(.DEPTH(4))   dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int nChecks = 0;
  int nFails  = 0;
  logic [39:0] sb[$];
  logic [39:0] sb4[$];
  logic [39:0] expW, expW4;
  logic [7:0]  expPtr;

  // Independent encoding model: {legal, word}.
  function automatic logic [32:0] modelWord(input int kind, input logic [4:0] rd, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm, input logic [25:0] tgt);
    case (kind)
      0:  return {1'b1, 6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      1:  return {1'b1, 6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      2:  return {1'b1, 6'b010000, rs, rt, imm};
      3:  return {1'b1, 6'b000100, rs, rt, rd, 5'd0, 6'b000001};
      4:  return {1'b1, 6'b000100, rs, rt, rd, 5'd0, 6'b000010};
      5:  return {1'b1, 6'b001100, rs, rt, rd, 5'd0, 6'b000001};
      6:  return {1'b1, 6'b001100, rs, rt, rd, 5'd0, 6'b000010};
      7:  return {1'b1, 6'b001100, rs, rt, rd, 5'd0, 6'b000011};
      8:  return {1'b1, 6'b010001, rs, rt, imm};
      9:  return {1'b1, 6'b010010, rs, rt, imm};
      10: return {1'b1, 6'b010101, rs, rt, imm};
      11: return {1'b1, 6'b010110, rs, rt, imm};
      12: return {1'b1, 6'b011101, rs, rt, imm};
      13: return {1'b1, 6'b011110, rs, rt, imm};
      14: return {1'b1, 6'b100000, rs, rt, imm};
      15: return {1'b1, 6'b100001, rs, rt, imm};
      16: return {1'b1, 6'b100010, tgt};
      17: return {1'b1, 6'b111111, rs, rt, imm};
      default: return 33'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      nChecks++;
      if (sb.size() == 0) begin
        nFails++;
        $display("[TB] FAIL write_unexpected: got write addr=%0d data=%h, required no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        expW = sb.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== expW) begin
          nFails++;
          $display("[TB] FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", bus.imem_addr, bus.imem_wdata, expW[39:32], expW[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.imem_we === 1'b1) begin
      nChecks++;
      if (sb4.size() == 0) begin
        nFails++;
        $display("[TB] FAIL write4_unexpected: got write addr=%0d data=%h, required no write", bus4.imem_addr, bus4.imem_wdata);
      end else begin
        expW4 = sb4.pop_front();
        if ({6'd0, bus4.imem_addr, bus4.imem_wdata} !== expW4) begin
          nFails++;
          $display("[TB] FAIL write4: got addr=%0d data=%h, required addr=%0d data=%h", bus4.imem_addr, bus4.imem_wdata, expW4[39:32], expW4[31:0]);
        end
      end
    end
  end

  // Entered just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [4:0] kind, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input logic expLegal, input logic [31:0] expWord);
    int waitCycles = 0;
    bus.req_kind = kind; bus.req_rd = rd; bus.req_rs = rs; bus.req_rt = rt;
    bus.req_imm = imm; bus.req_target = tgt; bus.req_last = last; bus.req_valid = 1'b1;
    if (expLegal) begin
      sb.push_back({expPtr, expWord});
      expPtr++;
    end
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (bus.req_ready !== 1'b1) begin
      nChecks++; nFails++;
      $display("[TB] FAIL handshake_timeout: got ready=%b, required 1", bus.req_ready);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_last  = 1'b0;
    end
  endtask

  task automatic startSession();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    expPtr = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nChecks++; if (bus.req_ready !== 1'b0)   begin nFails++; $display("[TB] FAIL reset_ready: got %b, required 0", bus.req_ready); end
    nChecks++; if (bus.imem_we !== 1'b0)     begin nFails++; $display("[TB] FAIL reset_we: got %b, required 0", bus.imem_we); end
    nChecks++; if (bus.busy !== 1'b0)        begin nFails++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
    nChecks++; if (bus.done !== 1'b0)        begin nFails++; $display("[TB] FAIL reset_done: got %b, required 0", bus.done); end
    nChecks++; if (bus.err !== 1'b0)         begin nFails++; $display("[TB] FAIL reset_err: got %b, required 0", bus.err); end
    nChecks++; if (bus.imem_addr !== 8'd0)   begin nFails++; $display("[TB] FAIL reset_addr: got %h, required 0", bus.imem_addr); end
    nChecks++; if (bus.imem_wdata !== 32'd0) begin nFails++; $display("[TB] FAIL reset_wdata: got %h, required 0", bus.imem_wdata); end
    nChecks++; if (bus.count !== 9'd0)       begin nFails++; $display("[TB] FAIL reset_count: got %0d, required 0", bus.count); end
    nChecks++; if (bus4.req_ready !== 1'b0)  begin nFails++; $display("[TB] FAIL reset4_ready: got %b, required 0", bus4.req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    startSession();
    @(negedge clk);
    nChecks++; if (bus.busy !== 1'b1)      begin nFails++; $display("[TB] FAIL add_busy: got %b, required 1", bus.busy); end
    nChecks++; if (bus.req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL add_ready: got %b, required 1", bus.req_ready); end
    @(posedge clk); #1;
    send(5'd0, 5'd3, 5'd1, 5'd2, 16'd0, 26'd0, 1'b1, 1'b1, 32'h00221820);
    @(negedge clk);
    nChecks++; if (bus.imem_we !== 1'b1)           begin nFails++; $display("[TB] FAIL add_we: got %b, required 1", bus.imem_we); end
    nChecks++; if (bus.imem_addr !== 8'd0)         begin nFails++; $display("[TB] FAIL add_addr: got %0d, required 0", bus.imem_addr); end
    nChecks++; if (bus.imem_wdata !== 32'h00221820) begin nFails++; $display("[TB] FAIL add_wdata: got %h, required 00221820", bus.imem_wdata); end
    nChecks++; if (bus.count !== 9'd1)             begin nFails++; $display("[TB] FAIL add_count: got %0d, required 1", bus.count); end
  endtask

  task automatic test_back_to_back();
    startSession();
    send(5'd2, 5'd0, 5'd0, 5'd5, 16'd7, 26'd0, 1'b0, 1'b1, 32'h40050007);
    send(5'd9, 5'd0, 5'd2, 5'd4, 16'd8, 26'd0, 1'b1, 1'b1, 32'h48440008);
    @(negedge clk);
    nChecks++; if (bus.imem_addr !== 8'd1)         begin nFails++; $display("[TB] FAIL b2b_addr: got %0d, required 1", bus.imem_addr); end
    nChecks++; if (bus.imem_wdata !== 32'h48440008) begin nFails++; $display("[TB] FAIL b2b_wdata: got %h, required 48440008", bus.imem_wdata); end
    nChecks++; if (bus.count !== 9'd2)             begin nFails++; $display("[TB] FAIL b2b_count: got %0d, required 2", bus.count); end
    nChecks++; if (bus.done !== 1'b1)              begin nFails++; $display("[TB] FAIL b2b_done: got %b, required 1", bus.done); end
  endtask

  task automatic test_jump();
    startSession();
    send(5'd16, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1, 1'b1, 32'h88000010);
    @(negedge clk);
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL j_busy: got %b, required 0", bus.busy); end
    nChecks++; if (bus.done !== 1'b1) begin nFails++; $display("[TB] FAIL j_done: got %b, required 1", bus.done); end
    repeat (3) @(negedge clk);
    nChecks++; if (bus.done !== 1'b1)               begin nFails++; $display("[TB] FAIL j_done_hold: got %b, required 1", bus.done); end
    nChecks++; if (bus.imem_we !== 1'b0)            begin nFails++; $display("[TB] FAIL j_we_pulse: got %b, required 0", bus.imem_we); end
    nChecks++; if (bus.imem_wdata !== 32'h88000010) begin nFails++; $display("[TB] FAIL j_wdata_hold: got %h, required 88000010", bus.imem_wdata); end
  endtask

  task automatic test_illegal();
    startSession();
    send(5'd0, 5'd3, 5'd1, 5'd2, 16'd0, 26'd0, 1'b0, 1'b1, 32'h00221820);
    send(5'd25, 5'd1, 5'd1, 5'd1, 16'h1234, 26'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    nChecks++; if (bus.err !== 1'b1)   begin nFails++; $display("[TB] FAIL ill_err: got %b, required 1", bus.err); end
    nChecks++; if (bus.count !== 9'd1) begin nFails++; $display("[TB] FAIL ill_count: got %0d, required 1", bus.count); end
    nChecks++; if (bus.busy !== 1'b1)  begin nFails++; $display("[TB] FAIL ill_busy: got %b, required 1", bus.busy); end
    @(posedge clk); #1;
    send(5'd1, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 1'b1, 1'b1, 32'h01093822);
    @(negedge clk);
    nChecks++; if (bus.imem_addr !== 8'd1) begin nFails++; $display("[TB] FAIL ill_addr: got %0d, required 1", bus.imem_addr); end
    nChecks++; if (bus.count !== 9'd2)     begin nFails++; $display("[TB] FAIL ill_count2: got %0d, required 2", bus.count); end
    nChecks++; if (bus.err !== 1'b1)       begin nFails++; $display("[TB] FAIL ill_err_sticky: got %b, required 1", bus.err); end
    nChecks++; if (bus.done !== 1'b1)      begin nFails++; $display("[TB] FAIL ill_done: got %b, required 1", bus.done); end
  endtask

  task automatic test_restart_collision();
    @(posedge clk); #1;
    expPtr = 8'd0;
    sb.push_back({8'd0, 32'h40050007});
    bus.start = 1'b1; bus.req_valid = 1'b1; bus.req_kind = 5'd2; bus.req_rs = 5'd0;
    bus.req_rt = 5'd5; bus.req_rd = 5'd0; bus.req_imm = 16'd7; bus.req_last = 1'b1;
    @(negedge clk);
    nChecks++; if (bus.req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL restart_ready: got %b, required 0", bus.req_ready); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    nChecks++; if (bus.err !== 1'b0)   begin nFails++; $display("[TB] FAIL restart_err: got %b, required 0", bus.err); end
    nChecks++; if (bus.count !== 9'd0) begin nFails++; $display("[TB] FAIL restart_count: got %0d, required 0", bus.count); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_last = 1'b0;
    @(negedge clk);
    nChecks++; if (bus.imem_we !== 1'b1) begin nFails++; $display("[TB] FAIL restart_we: got %b, required 1", bus.imem_we); end
    nChecks++; if (bus.imem_addr !== 8'd0) begin nFails++; $display("[TB] FAIL restart_addr: got %0d, required 0", bus.imem_addr); end
  endtask

  task automatic test_all_kinds();
    logic [32:0] m;
    logic [4:0] rd, rs, rt;
    logic [15:0] imm;
    logic [25:0] tgt;
    startSession();
    for (int k = 0; k < 18; k++) begin
      rd = 5'($urandom_range(0, 31)); rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      imm = 16'($urandom); tgt = 26'($urandom);
      m = modelWord(k, rd, rs, rt, imm, tgt);
      send(5'(k), rd, rs, rt, imm, tgt, (k == 17), m[32], m[31:0]);
    end
    @(negedge clk);
    nChecks++; if (bus.count !== 9'd18) begin nFails++; $display("[TB] FAIL kinds_count: got %0d, required 18", bus.count); end
    nChecks++; if (bus.err !== 1'b0)    begin nFails++; $display("[TB] FAIL kinds_err: got %b, required 0", bus.err); end
  endtask

  task automatic test_overflow();
    logic [32:0] m;
    @(posedge clk); #1;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0; bus4.req_valid = 1'b1; bus4.req_kind = 5'd0;
    bus4.req_rs = 5'd1; bus4.req_rt = 5'd2; bus4.req_rd = 5'd0; bus4.req_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nChecks++;
      if (bus4.req_ready !== (c < 4)) begin
        nFails++; $display("[TB] FAIL ovf_ready_c%0d: got %b, required %b", c, bus4.req_ready, (c < 4));
      end
      if (c < 4) begin
        m = modelWord(0, 5'(c), 5'd1, 5'd2, 16'd0, 26'd0);
        sb4.push_back({8'(c), m[31:0]});
      end
      if (c == 4) begin
        nChecks++; if (bus4.count !== 3'd4) begin nFails++; $display("[TB] FAIL ovf_count: got %0d, required 4", bus4.count); end
      end
      if (c == 5) begin
        nChecks++; if (bus4.err !== 1'b1)  begin nFails++; $display("[TB] FAIL ovf_err: got %b, required 1", bus4.err); end
        nChecks++; if (bus4.done !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_done: got %b, required 1", bus4.done); end
      end
      @(posedge clk); #1;
      bus4.req_rd = 5'(c + 1);
    end
    bus4.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    startSession();
    send(5'd0, 5'd3, 5'd1, 5'd2, 16'd0, 26'd0, 1'b0, 1'b1, 32'h00221820);
    bus.req_kind = 5'd2; bus.req_rt = 5'd6; bus.req_imm = 16'd9; bus.req_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    nChecks++; if (bus.imem_we !== 1'b0)     begin nFails++; $display("[TB] FAIL rst_we: got %b, required 0", bus.imem_we); end
    nChecks++; if (bus.busy !== 1'b0)        begin nFails++; $display("[TB] FAIL rst_busy: got %b, required 0", bus.busy); end
    nChecks++; if (bus.req_ready !== 1'b0)   begin nFails++; $display("[TB] FAIL rst_ready: got %b, required 0", bus.req_ready); end
    nChecks++; if (bus.count !== 9'd0)       begin nFails++; $display("[TB] FAIL rst_count: got %0d, required 0", bus.count); end
    nChecks++; if (bus.imem_wdata !== 32'd0) begin nFails++; $display("[TB] FAIL rst_wdata: got %h, required 0", bus.imem_wdata); end
    startSession();
    send(5'd2, 5'd0, 5'd0, 5'd5, 16'd7, 26'd0, 1'b1, 1'b1, 32'h40050007);
    @(negedge clk);
    nChecks++; if (bus.imem_addr !== 8'd0) begin nFails++; $display("[TB] FAIL rst_fresh_addr: got %0d, required 0", bus.imem_addr); end
  endtask

  initial begin
    bus.start = 1'b0; bus.req_valid = 1'b0; bus.req_kind = '0; bus.req_rd = '0; bus.req_rs = '0;
    bus.req_rt = '0; bus.req_imm = '0; bus.req_target = '0; bus.req_last = 1'b0;
    bus4.start = 1'b0; bus4.req_valid = 1'b0; bus4.req_kind = '0; bus4.req_rd = '0; bus4.req_rs = '0;
    bus4.req_rt = '0; bus4.req_imm = '0; bus4.req_target = '0; bus4.req_last = 1'b0;
    expPtr = 8'd0;
    test_reset();
    test_add();
    test_back_to_back();
    test_jump();
    test_illegal();
    test_restart_collision();
    test_all_kinds();
    test_overflow();
    test_reset_mid();
    repeat (3) @(negedge clk);
    nChecks++; if (sb.size() != 0)  begin nFails++; $display("[TB] FAIL sb_drain: got %0d pending, required 0", sb.size()); end
    nChecks++; if (sb4.size() != 0) begin nFails++; $display("[TB] FAIL sb4_drain: got %0d pending, required 0", sb4.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and program loader: the encode-side counterpart of the main control decoder. It accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready stream, packs each into a 32-bit instruction word whose opcode the main decoder understands, and writes the words sequentially into instruction memory. It sits between the testbench/host program source and the instruction memory write port. It runs before the core is released from reset.

## Interface
- DEPTH, 256: instruction memory depth in words.
- ADDR_W, $clog2(DEPTH): word-address width.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load session; the word pointer restarts at 0.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_kind  in  5  instr_kind_t.
- req_rd, req_rs, req_rt  in  5 each  register fields.
- req_imm  in  16  immediate or branch offset.
- req_target  in  26  jump target.
- req_last  in  1  last instruction of the program.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- busy  out  1  state is LOAD.
- done  out  1  session finished; held high until the next start.
- err  out  1  sticky error for the current session.
- count  out  ADDR_W+1  words written this session.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start moves to LOAD.
  - LOAD: accept requests. Move to DONE after the cycle that accepts req_last, or on overflow.
  - DONE: start moves to LOAD. start has no effect while in LOAD.
- start clears wr_ptr, count and err.
- req_ready = (state==LOAD) && (count<DEPTH).
- Overflow: req_valid while count==DEPTH in LOAD sets err and moves to DONE. Nothing is written.
- Opcodes:
  - R-type add/sub: 000000
  - addi: 010000
  - add.fp/mul.fp: 000100
  - vadd.fp/vmul.fp/vsum.fp: 001100
  - sw: 010001
  - lw: 010010
  - sw.fp: 010101
  - lw.fp: 010110
  - vst: 011101
  - vld: 011110
  - beq: 100000
  - blt: 100001
  - j: 100010
  - vset.fp: 111111
- Funct values, taken from the kind:
  - add: 100000
  - sub: 100010
  - add.fp / vadd.fp: 000001
  - mul.fp / vmul.fp: 000010
  - vsum.fp: 000011
- Word formats:
  - R format, for the add/sub and fp/vector-fp groups: {op, rs, rt, rd, 5'b0, funct}.
  - I format, for addi, all loads and stores, beq, blt and vset.fp: {op, rs, rt, imm}. Loads use rt as destination. Branch imm is a signed word offset, passed through unchanged.
  - J format: {op, target}.
- Illegal kind (value 18..31): accepted (handshake completes), not written, not counted, err set. If req_last is set on it, the FSM still moves to DONE.

## Timing
- Reset values:
  - state = IDLE.
  - req_ready, imem_we, busy, done, err = 0.
  - imem_addr = 0, imem_wdata = 0, count = 0.
- Latency: a legal request accepted in cycle N produces imem_we=1 in cycle N+1, with imem_addr=wr_ptr and imem_wdata registered.
- wr_ptr and count increment on that write. Full throughput is one word per cycle.
- imem_we is a one-cycle pulse per word. imem_addr/imem_wdata hold their last values when imem_we=0.
- done rises in the cycle of the final write, or in the cycle after the final accept if that request was illegal. The final write completes even though the state is already DONE.
- Reset in any state or cycle: all outputs and state return to reset values next edge. A write pending from the previous cycle is discarded.
- Boundaries:
  - Accepting the DEPTH-th word drops req_ready the next cycle.
  - wr_ptr never wraps within a session.
  - start in DONE in the same cycle as req_valid: the request is not accepted that cycle.

## Structure
- isa_pkg holds:
  - instr_kind_t enum, with values 0..17 in the listed order: ADD, SUB, ADDI, ADDFP, MULFP, VADDFP, VMULFP, VSUMFP, SW, LW, SWFP, LWFP, VST, VLD, BEQ, BLT, J, VSETFP.
  - opcode and funct localparams.
  - instruction field width constants.
- The main decoder shares these constants.
- One sub-module, instr_pack: purely combinational kind/fields to {legal, word32}. The instr_encoder top holds the FSM, counters and output register.

## Test plan
- ADD with rd=3, rs=1, rt=2 after start -> one cycle later imem_we=1, addr 0, wdata 0x00221820, count=1.
- Back-to-back ADDI (rt=5, rs=0, imm=7) then LW (rt=4, rs=2, imm=8, last) -> consecutive writes 0x40050007 @0 and 0x48440008 @1; done=1, count=2.
- J with target=0x10, last -> wdata 0x88000010; busy falls; done stays high until the next start.
- Illegal kind 25 between two legal requests -> handshake completes, err=1, the two legal words land at addresses 0 and 1.
- DEPTH=4: 5 requests without last -> 4 writes, ready low after the 4th accept, 5th valid gives err=1 and done=1.
- Reset asserted the cycle after an accept -> no imem_we, all outputs zero, state IDLE; a fresh start writes at address 0.
